timer_regif: RTL and testbench

Memory-mapped register front-end for the timing counter block; the CPU-side responder that drives the counter's trigger, mode and terminal-count inputs. It samples the counter's status, count and interrupt outputs back.
- Accepts single-beat read/write requests with a valid/ready handshake and returns one response per request.
- Turns register writes into one-cycle START/HALT pulses.
- Latches counter interrupt pulses into a sticky pending flag that drives a level irq to the interrupt controller.

---
 rtl/timer_pkg.sv | 28 ++
 rtl/timer_regif_if.sv | 33 +++
 rtl/timer_regif.sv | 179 +++++++++++++++++
 tb/tb_timer_regif.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the timer register front-end: register offsets,
// CTRL/STATUS bit positions and the bus FSM state encoding.
package timer_pkg;

    // Word-aligned register offsets (byte addresses).
    localparam logic [31:0] OFF_CTRL   = 32'h00;
    localparam logic [31:0] OFF_TERM   = 32'h04;
    localparam logic [31:0] OFF_STATUS = 32'h08;
    localparam logic [31:0] OFF_COUNT  = 32'h0C;
    localparam logic [31:0] OFF_IRQCNT = 32'h10;

    // CTRL bit positions.
    localparam int CTRL_START  = 0;
    localparam int CTRL_HALT   = 1;
    localparam int CTRL_MODE   = 2;
    localparam int CTRL_IRQ_EN = 3;

    // STATUS bit positions.
    localparam int STAT_RUNNING = 0;
    localparam int STAT_PENDING = 1;

    // Bus FSM: IDLE accepts a request, RESP holds the response until consumed.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

endpackage

// File: rtl/timer_regif_if.sv
// Request/response bus for the timer register front-end.
// Handshake: a request transfers on a cycle where req_valid and req_ready are
// both 1; a response transfers on a cycle where rsp_valid and rsp_ready are
// both 1. The master holds req_* stable while req_valid is 1 and not yet
// accepted; the slave holds rsp_rdata/rsp_err stable while rsp_valid is 1 and
// not yet consumed. state mirrors the slave's bus FSM for observation.
interface timer_regif_if #(
    parameter int ADDR_W = 5
);
    import timer_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    state_t            state;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, state
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, state
    );

endinterface

// File: rtl/timer_regif.sv
// Register front-end for the timing counter: decodes single-beat bus
// accesses, drives trigger pulses / mode / terminal count to the counter and
// keeps a sticky interrupt-pending flag that drives a level irq.
// Optional: TIMER_REGIF_IRQCNT_EN adds the IRQCNT register at 0x10.
module timer_regif
    import timer_pkg::*;
#(
    parameter int          ADDR_W     = 5,
    parameter logic [31:0] TERM_RESET = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    timer_regif_if.slave         bus,
    output logic                 tmr_trig_start,
    output logic                 tmr_trig_halt,
    output logic                 tmr_mode,
    output logic [31:0]          tmr_termcount,
    input  logic                 tmr_status,
    input  logic [31:0]          tmr_currcount,
    input  logic                 tmr_int,
    output logic                 irq
);

    state_t      state;
    logic        irq_en;
    logic        pending;
`ifdef TIMER_REGIF_IRQCNT_EN
    logic [31:0] irqcnt;
`endif

    logic        accept;
    logic        hit;
    logic [31:0] rd_data;
    logic [31:0] addr_ext;
    logic        wr_ctrl;
    logic        wr_term;
    logic        wr_status;
    logic        pend_clr;
`ifdef TIMER_REGIF_IRQCNT_EN
    logic        wr_irqcnt;
`endif

    assign bus.state = state;
    assign accept    = (state == ST_IDLE) && bus.req_valid;

    // Address decode and read-data mux, evaluated on the accept cycle.
    always_comb begin
        addr_ext = 32'(bus.req_addr);
        hit      = 1'b0;
        rd_data  = 32'h0;
        if (addr_ext[1:0] == 2'b00) begin
            case (addr_ext)
                OFF_CTRL: begin
                    hit                  = 1'b1;
                    rd_data[CTRL_MODE]   = tmr_mode;
                    rd_data[CTRL_IRQ_EN] = irq_en;
                end
                OFF_TERM: begin
                    hit     = 1'b1;
                    rd_data = tmr_termcount;
                end
                OFF_STATUS: begin
                    hit                   = 1'b1;
                    rd_data[STAT_RUNNING] = tmr_status;
                    rd_data[STAT_PENDING] = pending;
                end
                OFF_COUNT: begin
                    hit     = 1'b1;
                    rd_data = tmr_currcount;
                end
`ifdef TIMER_REGIF_IRQCNT_EN
                OFF_IRQCNT: begin
                    hit     = 1'b1;
                    rd_data = irqcnt;
                end
`endif
                default: begin
                    hit     = 1'b0;
                    rd_data = 32'h0;
                end
            endcase
        end
    end

    // Write strobes; an erroring access never reaches here because hit is 0.
    always_comb begin
        wr_ctrl   = accept && bus.req_write && hit && (addr_ext == OFF_CTRL);
        wr_term   = accept && bus.req_write && hit && (addr_ext == OFF_TERM);
        wr_status = accept && bus.req_write && hit && (addr_ext == OFF_STATUS);
        pend_clr  = wr_status && bus.req_wdata[STAT_PENDING];
`ifdef TIMER_REGIF_IRQCNT_EN
        wr_irqcnt = accept && bus.req_write && hit && (addr_ext == OFF_IRQCNT);
`endif
    end

    // Bus FSM with registered handshake/response outputs and control pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            bus.req_ready  <= 1'b1;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_rdata  <= 32'h0;
            bus.rsp_err    <= 1'b0;
            tmr_trig_start <= 1'b0;
            tmr_trig_halt  <= 1'b0;
        end else begin
            // START wins over HALT when both are written in one access.
            tmr_trig_start <= wr_ctrl && bus.req_wdata[CTRL_START];
            tmr_trig_halt  <= wr_ctrl && bus.req_wdata[CTRL_HALT]
                              && !bus.req_wdata[CTRL_START];
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        state         <= ST_RESP;
                        bus.req_ready <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_rdata <= (hit && !bus.req_write) ? rd_data : 32'h0;
                        bus.rsp_err   <= !hit;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state         <= ST_IDLE;
                        bus.req_ready <= 1'b1;
                        bus.rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    bus.req_ready <= 1'b1;
                    bus.rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    // Configuration registers written from the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmr_mode      <= 1'b0;
            irq_en        <= 1'b0;
            tmr_termcount <= TERM_RESET;
        end else begin
            if (wr_ctrl) begin
                tmr_mode <= bus.req_wdata[CTRL_MODE];
                irq_en   <= bus.req_wdata[CTRL_IRQ_EN];
            end
            if (wr_term) begin
                tmr_termcount <= bus.req_wdata;
            end
        end
    end

    // Sticky pending flag (a new interrupt beats a simultaneous clear) and
    // the registered level irq derived from it.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= 1'b0;
            irq     <= 1'b0;
        end else begin
            pending <= tmr_int || (pending && !pend_clr);
            irq     <= pending && irq_en;
        end
    end

`ifdef TIMER_REGIF_IRQCNT_EN
    // Saturating interrupt counter; a bus write clears it and beats an increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            irqcnt <= 32'h0;
        end else if (wr_irqcnt) begin
            irqcnt <= 32'h0;
        end else if (tmr_int && (irqcnt != 32'hFFFF_FFFF)) begin
            irqcnt <= irqcnt + 32'h1;
        end
    end
`endif

endmodule

// File: tb/tb_timer_regif.sv
// Directed plus randomized bench for timer_regif. A reference model of the
// register file (plain variables updated per the register rules) predicts
// read data, errors, pulses, mode/term outputs and irq.
module tb_timer_regif;
    import timer_pkg::*;

    localparam logic [31:0] TB_TERM_RESET = 32'h0000_0010;

    logic        clk;
    logic        reset;
    logic        tmr_trig_start;
    logic        tmr_trig_halt;
    logic        tmr_mode;
    logic [31:0] tmr_termcount;
    logic        tmr_status;
    logic [31:0] tmr_currcount;
    logic        tmr_int;
    logic        irq;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic        m_mode;
    logic        m_irq_en;
    logic [31:0] m_term;
    logic        m_pending;
    logic [31:0] m_irqcnt;

    timer_regif_if #(.ADDR_W(5)) bus ();

    timer_regif #(
        .ADDR_W     (5),
        .TERM_RESET (TB_TERM_RESET)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .tmr_trig_start (tmr_trig_start),
        .tmr_trig_halt  (tmr_trig_halt),
        .tmr_mode       (tmr_mode),
        .tmr_termcount  (tmr_termcount),
        .tmr_status     (tmr_status),
        .tmr_currcount  (tmr_currcount),
        .tmr_int        (tmr_int),
        .irq            (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_mode    = 1'b0;
        m_irq_en  = 1'b0;
        m_term    = TB_TERM_RESET;
        m_pending = 1'b0;
        m_irqcnt  = 32'h0;
    endtask

    function automatic logic addr_ok(input logic [4:0] a);
        if (a[1:0] != 2'b00) return 1'b0;
        if (a == 5'h00 || a == 5'h04 || a == 5'h08 || a == 5'h0C) return 1'b1;
`ifdef TIMER_REGIF_IRQCNT_EN
        if (a == 5'h10) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // One complete transaction: request, optional response back-pressure,
    // response consumption. intr drives tmr_int during the accept cycle.
    task automatic access(input logic wr, input logic [4:0] a, input logic [31:0] wd,
                          input logic intr, input int hold, output logic [31:0] rdata);
        logic        ok;
        logic [31:0] exp_rd;
        logic        exp_start;
        logic        exp_halt;
        logic        cnt_cleared;
        logic        run;
        logic [31:0] cnt;
        run = 1'($urandom_range(0, 1));
        cnt = $urandom;
        chk("req_ready_idle", 32'(bus.req_ready), 32'h1);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        tmr_status    = run;
        tmr_currcount = cnt;
        tmr_int       = intr;
        ok     = addr_ok(a);
        exp_rd = 32'h0;
        if (ok && !wr) begin
            case (a)
                5'h00:   exp_rd = {28'h0, m_irq_en, m_mode, 2'b00};
                5'h04:   exp_rd = m_term;
                5'h08:   exp_rd = {30'h0, m_pending, run};
                5'h0C:   exp_rd = cnt;
                default: exp_rd = m_irqcnt;
            endcase
        end
        exp_start   = ok && wr && a == 5'h00 && wd[0];
        exp_halt    = ok && wr && a == 5'h00 && wd[1] && !wd[0];
        cnt_cleared = 1'b0;
        if (ok && wr) begin
            case (a)
                5'h00: begin m_mode = wd[2]; m_irq_en = wd[3]; end
                5'h04: m_term = wd;
                5'h08: if (wd[1]) m_pending = 1'b0;
                5'h10: begin m_irqcnt = 32'h0; cnt_cleared = 1'b1; end
                default: ;
            endcase
        end
        if (intr) begin
            m_pending = 1'b1;
            if (!cnt_cleared && m_irqcnt != 32'hFFFF_FFFF) m_irqcnt = m_irqcnt + 1;
        end
        tick();
        bus.req_valid = 1'b0;
        tmr_int       = 1'b0;
        chk("rsp_valid", 32'(bus.rsp_valid), 32'h1);
        chk("req_ready_busy", 32'(bus.req_ready), 32'h0);
        chk("rsp_rdata", bus.rsp_rdata, exp_rd);
        chk("rsp_err", 32'(bus.rsp_err), 32'(!ok));
        chk("trig_start", 32'(tmr_trig_start), 32'(exp_start));
        chk("trig_halt", 32'(tmr_trig_halt), 32'(exp_halt));
        chk("tmr_mode", 32'(tmr_mode), 32'(m_mode));
        chk("tmr_termcount", tmr_termcount, m_term);
        for (int i = 0; i < hold; i++) begin
            bus.rsp_ready = 1'b0;
            tick();
            chk("hold_rsp_valid", 32'(bus.rsp_valid), 32'h1);
            chk("hold_req_ready", 32'(bus.req_ready), 32'h0);
            chk("hold_rdata", bus.rsp_rdata, exp_rd);
            chk("hold_err", 32'(bus.rsp_err), 32'(!ok));
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("rsp_done", 32'(bus.rsp_valid), 32'h0);
        chk("req_ready_back", 32'(bus.req_ready), 32'h1);
        chk("pulses_low", {30'h0, tmr_trig_start, tmr_trig_halt}, 32'h0);
        chk("irq_level", 32'(irq), 32'(m_pending && m_irq_en));
        rdata = bus.rsp_rdata;
    endtask

    task automatic pulse_int();
        tmr_int = 1'b1;
        tick();
        tmr_int = 1'b0;
        m_pending = 1'b1;
        if (m_irqcnt != 32'hFFFF_FFFF) m_irqcnt = m_irqcnt + 1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'h1);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
        chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'h0);
        chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'h0);
        chk({tag, "_pulses"}, {30'h0, tmr_trig_start, tmr_trig_halt}, 32'h0);
        chk({tag, "_mode"}, 32'(tmr_mode), 32'h0);
        chk({tag, "_term"}, tmr_termcount, TB_TERM_RESET);
        chk({tag, "_irq"}, 32'(irq), 32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        logic [4:0]  a;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 5'h0;
        bus.req_wdata = 32'h0;
        bus.rsp_ready = 1'b0;
        tmr_status    = 1'b0;
        tmr_currcount = 32'h0;
        tmr_int       = 1'b0;
        reset         = 1'b1;
        model_reset();
        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();

        // TERM=5 then START|MODE; STATUS bit0 follows tmr_status.
        access(1'b1, 5'h04, 32'h5, 1'b0, 0, rd);
        access(1'b1, 5'h00, 32'h5, 1'b0, 0, rd);
        chk("term5", tmr_termcount, 32'h5);
        chk("mode1", 32'(tmr_mode), 32'h1);
        access(1'b0, 5'h08, 32'h0, 1'b0, 0, rd);

        // Enable irq, pulse tmr_int: irq rises the cycle after pending.
        access(1'b1, 5'h00, 32'h8, 1'b0, 0, rd);
        tmr_int = 1'b1;
        tick();
        tmr_int = 1'b0;
        m_pending = 1'b1;
        if (m_irqcnt != 32'hFFFF_FFFF) m_irqcnt = m_irqcnt + 1;
        chk("irq_not_yet", 32'(irq), 32'h0);
        tick();
        chk("irq_set", 32'(irq), 32'h1);
        access(1'b0, 5'h08, 32'h0, 1'b0, 0, rd);
        chk("pending_read", rd & 32'h2, 32'h2);

        // W1C: irq falls one cycle after the clear lands.
        access(1'b1, 5'h08, 32'h2, 1'b0, 0, rd);
        chk("irq_cleared", 32'(irq), 32'h0);

        // W1C coincident with tmr_int: pending and irq stay set.
        pulse_int();
        tick();
        chk("irq_before_race", 32'(irq), 32'h1);
        access(1'b1, 5'h08, 32'h2, 1'b1, 0, rd);
        chk("irq_after_race", 32'(irq), 32'h1);

        // START and HALT together: only START.
        access(1'b1, 5'h00, 32'h3, 1'b0, 0, rd);
        // HALT alone.
        access(1'b1, 5'h00, 32'h2, 1'b0, 0, rd);

        // Misaligned and unmapped accesses, with back-pressure.
        access(1'b1, 5'h02, 32'hDEAD_BEEF, 1'b0, 3, rd);
        access(1'b1, 5'h14, 32'h0000_000F, 1'b0, 3, rd);
        access(1'b0, 5'h14, 32'h0, 1'b0, 2, rd);
        access(1'b1, 5'h10, 32'h0, 1'b0, 1, rd);

`ifdef TIMER_REGIF_IRQCNT_EN
        // Three interrupts after a clear read back as 3.
        repeat (3) pulse_int();
        tick();
        access(1'b0, 5'h10, 32'h0, 1'b0, 0, rd);
        chk("irqcnt3", rd, 32'h3);
`endif

        // Reset in the middle of a response after a START write.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 5'h00;
        bus.req_wdata = 32'h1;
        tick();
        bus.req_valid = 1'b0;
        chk("pre_reset_rsp", 32'(bus.rsp_valid), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        check_reset_outputs("midrsp");
        tick();
        chk("no_pulse_after_reset", {30'h0, tmr_trig_start, tmr_trig_halt}, 32'h0);
        access(1'b0, 5'h08, 32'h0, 1'b0, 0, rd);

        // Randomized traffic against the model.
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 9))
                0: a = 5'h00;
                1: a = 5'h04;
                2: a = 5'h08;
                3: a = 5'h0C;
                4: a = 5'h10;
                5: a = 5'h14;
                6: a = 5'h1C;
                default: a = 5'($urandom_range(0, 31));
            endcase
            access(1'($urandom_range(0, 1)), a,
                   ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 15)),
                   $urandom_range(0, 3) == 0, int'($urandom_range(0, 2)), rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
